// File: rtl/time_mux_pkg.sv
// Shared definitions for the time-multiplexed link (mux and demux sides).
// Provides the frame-alignment state type and the expected-strobe helper.
package time_mux_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    // One-hot strobe for slot idx; zero when idx is outside 0..m-1.
    function automatic logic [31:0] onehot(input int unsigned idx, input int unsigned m);
        return (idx < m) ? (32'd1 << idx) : '0;
    endfunction

endpackage

// File: rtl/time_demux_onehot_enc.sv
// Combinational classifier for the slot strobe: idle, one-hot, and the set bit's index.
// For multi-hot inputs index reports the highest set bit and is_onehot is low.
module onehot_enc #(
    parameter int M = 2
) (
    input  logic [M-1:0]         b,
    output logic                 is_zero,
    output logic                 is_onehot,
    output logic [$clog2(M)-1:0] index
);

    localparam int IW = $clog2(M);

    int unsigned cnt;

    always_comb begin
        cnt   = 0;
        index = '0;
        for (int unsigned i = 0; i < M; i++) begin
            if (b[i]) begin
                cnt   = cnt + 1;
                index = IW'(i);
            end
        end
        is_zero   = (cnt == 0);
        is_onehot = (cnt == 1);
    end

endmodule

// File: rtl/time_demux.sv
// Receive side of the time-multiplexed link: reassembles M slots of N bits into frames.
// Optional TIME_DEMUX_ERR_EN adds the frame_err pulse and saturating err_count.
module time_demux
    import time_mux_pkg::*;
#(
    parameter int N = 1,
    parameter int M = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   y_in,
    input  logic [M-1:0]   b_in,
    output logic [M*N-1:0] d_out,
    output logic           valid
`ifdef TIME_DEMUX_ERR_EN
    ,
    output logic           frame_err,
    output logic [7:0]     err_count
`endif
);

    localparam int IW = $clog2(M);

    state_t               state;
    logic [IW-1:0]        idx;
    logic [(M-1)*N-1:0]   shadow;

    logic                 is_zero;
    logic                 is_onehot;
    logic [IW-1:0]        b_idx;
    logic                 is_slot0;
    logic                 is_expected;

    onehot_enc #(.M(M)) u_enc (
        .b         (b_in),
        .is_zero   (is_zero),
        .is_onehot (is_onehot),
        .index     (b_idx)
    );

    always_comb begin
        is_slot0    = is_onehot && (b_idx == '0);
        is_expected = (b_in == M'(onehot(32'(idx), M)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= HUNT;
            idx    <= '0;
            shadow <= '0;
            d_out  <= '0;
            valid  <= 1'b0;
`ifdef TIME_DEMUX_ERR_EN
            frame_err <= 1'b0;
            err_count <= '0;
`endif
        end else begin
            valid <= 1'b0;
`ifdef TIME_DEMUX_ERR_EN
            frame_err <= 1'b0;
`endif
            case (state)
                HUNT: begin
                    if (is_slot0) begin
                        shadow[N-1:0] <= y_in;
                        idx           <= IW'(1);
                        state         <= LOCK;
                    end
                end
                LOCK: begin
                    if (is_zero) begin
                        // idle slot: hold alignment and partial frame
                    end else if (is_expected) begin
                        if (idx == IW'(M-1)) begin
                            d_out <= {y_in, shadow};
                            valid <= 1'b1;
                            idx   <= '0;
                            state <= HUNT;
                        end else begin
                            for (int unsigned i = 0; i < M-1; i++) begin
                                if (idx == IW'(i)) shadow[i*N +: N] <= y_in;
                            end
                            idx <= idx + IW'(1);
                        end
                    end else begin
`ifdef TIME_DEMUX_ERR_EN
                        frame_err <= 1'b1;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
                        // a misplaced slot 0 starts a fresh frame immediately
                        if (is_slot0) begin
                            shadow[N-1:0] <= y_in;
                            idx           <= IW'(1);
                        end else begin
                            idx   <= '0;
                            state <= HUNT;
                        end
                    end
                end
                default: begin
                    idx   <= '0;
                    state <= HUNT;
                end
            endcase
        end
    end

endmodule
